// File: rtl/pipelined_adder_subtractor.sv
// Pipelined two's-complement adder/subtractor.
// Resolves one CHUNK-bit slice per stage, with the carry registered between
// slices. A single advance enable gates every stage, which gives valid/ready
// backpressure. The final register holds sum and its flags.
module pipelined_adder_subtractor #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int CHUNK = WIDTH / STAGES;
   // Number of intermediate stage registers. This is kept at least 1 so that
   // STAGES=1 still elaborates, although it leaves those registers unused.
   localparam int MID   = (STAGES > 1) ? STAGES - 1 : 1;

   // x carries a with the finished low slices overwritten by sum bits.
   // y carries b_eff.
   logic [WIDTH-1:0] x_q [MID];
   logic [WIDTH-1:0] y_q [MID];
   logic [WIDTH-1:0] x_d [MID];
   logic [WIDTH-1:0] y_d [MID];
   logic [MID-1:0]   c_q, c_d, v_q, v_d;

   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, valid_q, valid_d;
   logic             advance;

   assign advance   = !valid_q || out_ready;
   assign in_ready  = advance;
   assign out_valid = valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

   // Per-stage slice addition; each stage's result feeds the next stage register.
   always_comb begin
      logic [WIDTH-1:0] xi;
      logic [WIDTH-1:0] yi;
      logic             ci;
      logic             vi;
      logic             a_msb;
      logic [CHUNK:0]   part;
      xi      = '0;
      yi      = '0;
      ci      = 1'b0;
      vi      = 1'b0;
      a_msb   = 1'b0;
      part    = '0;
      c_d     = '0;
      v_d     = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
      ovf_d   = 1'b0;
      zero_d  = 1'b0;
      valid_d = 1'b0;
      for (int m = 0; m < MID; m++) begin
         x_d[m] = '0;
         y_d[m] = '0;
      end
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            // Idle inputs are zeroed so that they never reach state.
            vi = in_valid;
            xi = in_valid ? a : '0;
            yi = in_valid ? (b ^ {WIDTH{sub_en}}) : '0;
            ci = in_valid & (cin ^ sub_en);
         end else begin
            vi = v_q[k-1];
            xi = x_q[k-1];
            yi = y_q[k-1];
            ci = c_q[k-1];
         end
         a_msb = xi[WIDTH-1];
         part  = {1'b0, xi[k*CHUNK +: CHUNK]} + {1'b0, yi[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, ci};
         xi[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
         if (k < STAGES - 1) begin
            x_d[k] = xi;
            y_d[k] = yi;
            c_d[k] = part[CHUNK];
            v_d[k] = vi;
         end else begin
            sum_d   = xi;
            cout_d  = part[CHUNK];
            // The carry into the MSB is recovered as a ^ b_eff ^ sum at that bit.
            ovf_d   = a_msb ^ yi[WIDTH-1] ^ xi[WIDTH-1] ^ part[CHUNK];
            // zero is forced low for bubbles so that it is only ever set together with valid.
            zero_d  = vi && (xi == '0);
            valid_d = vi;
         end
      end
   end

   // Stage and output registers, all gated by the global advance enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int m = 0; m < MID; m++) begin
            x_q[m] <= '0;
            y_q[m] <= '0;
         end
         c_q     <= '0;
         v_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (advance) begin
         for (int m = 0; m < MID; m++) begin
            x_q[m] <= x_d[m];
            y_q[m] <= y_d[m];
         end
         c_q     <= c_d;
         v_q     <= v_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Self-checking bench for pipelined_adder_subtractor.
// Uses directed corner cases, back-to-back traffic, a stall and a reset
// mid-flight, then random traffic with random backpressure.
module tb_pipelined_adder_subtractor;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a, b;
   logic             cin, sub_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout, overflow, zero;

   int checks = 0;
   int errors = 0;

   logic [34:0] exp_q [$];
   logic [34:0] held;
   logic        prev_stall = 1'b0;

   pipelined_adder_subtractor #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub_en    (sub_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference result {sum, cout, overflow, zero} computed with plain wide arithmetic.
   function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic s);
      logic [31:0] be;
      logic [32:0] full;
      logic        ov;
      be   = s ? ~y : y;
      full = {1'b0, x} + {1'b0, be} + {32'd0, ci ^ s};
      ov   = (x[31] == be[31]) && (full[31] != x[31]);
      return {full[31:0], full[32], ov, full[31:0] == 32'd0};
   endfunction

   // Scoreboard: record accepted ops, compare delivered results, watch stall stability.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall)
            chk("stall_hold", {29'd0, out_valid, sum, cout, overflow, zero}, {29'd1, held});
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 1, 0);
            else chk("result", {29'd0, sum, cout, overflow, zero}, {29'd0, exp_q.pop_front()});
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub_en));
         prev_stall = out_valid && !out_ready;
         held       = {sum, cout, overflow, zero};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic set_rand_op();
      a      = $urandom;
      b      = $urandom;
      cin    = 1'($urandom_range(0, 1));
      sub_en = 1'($urandom_range(0, 1));
   endtask

   task automatic send_wait(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic ci, input logic s, input logic [31:0] es,
                            input logic ec, input logic eo, input logic ez);
      int n;
      a = x; b = y; cin = ci; sub_en = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      set_rand_op();
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_lat"}, n, STAGES);
      chk({tag, "_sum"}, sum, es);
      chk({tag, "_cout"}, cout, ec);
      chk({tag, "_ovf"}, overflow, eo);
      chk({tag, "_zero"}, zero, ez);
   endtask

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, exp_q.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub_en = 1'b0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_zero", zero, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_wait("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      send_wait("add_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      send_wait("sub_eq", 32'h5, 32'h5, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
      send_wait("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      send_wait("sub_borrow", 32'h0, 32'h1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      send_wait("add_cin", 32'h10, 32'h20, 1'b1, 1'b0, 32'h31, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;

      // Back-to-back traffic: one result per cycle, the first at cycle 4.
      for (int i = 0; i < 8; i++) begin
         chk("b2b_in_ready", in_ready, 1);
         set_rand_op();
         in_valid = 1'b1;
         @(posedge clk); #1;
         chk("b2b_out_valid", out_valid, (i >= STAGES - 1) ? 1 : 0);
      end
      in_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
         chk("b2b_tail_valid", out_valid, (j < 3) ? 1 : 0);
      end
      wait_drain("b2b_drain");

      // Fill the pipeline, then stall for 3 cycles with a pending input.
      for (int i = 0; i < 4; i++) begin
         set_rand_op();
         in_valid = 1'b1;
         if (i == 3) out_ready = 1'b0;
         @(posedge clk); #1;
      end
      set_rand_op();
      for (int s = 0; s < 3; s++) begin
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid", out_valid, 1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_drain("stall_drain");

      // Asynchronous reset with 3 operations in flight.
      for (int i = 0; i < 3; i++) begin
         set_rand_op();
         in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_sum", sum, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      #10;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         set_rand_op();
         @(posedge clk); #1;
         chk("post_rst_idle", out_valid, 0);
      end

      // Random traffic with random backpressure and garbage on idle inputs.
      for (int i = 0; i < 400; i++) begin
         set_rand_op();
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_drain("rand_drain");
      @(posedge clk); #1;
      chk("final_idle", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_adder_subtractor.md
Name: pipelined_adder_subtractor

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the MIPS32 datapath. Next generation of the 32-bit ripple adder/subtractor.
- Splits a WIDTH-bit operation into STAGES equal chunks. One chunk is resolved per clock, with the carry registered between chunks.
- Adds a valid/ready handshake with backpressure, plus signed-overflow and zero flags, so it can run at high clock rates inside the ALU and multiply/divide helpers.

Parameters:
- WIDTH, 32, operand and result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH). CHUNK = WIDTH/STAGES bits are resolved per stage.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or extra borrow (sub).
- sub_en  input  1  1 = subtract, 0 = add.
- out_valid  output  1  result held on the outputs.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB (no-borrow indicator when subtracting).
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Arithmetic:
  - b_eff = b XOR {WIDTH{sub_en}}.
  - carry0 = cin XOR sub_en.
  - sum = a + b_eff + carry0, modulo 2^WIDTH.
  - Consequences: sub_en=1, cin=0 gives a-b; sub_en=1, cin=1 gives a-b-1; sub_en=0, cin=1 gives a+b+1.
- Flags:
  - cout = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR cout.
  - zero = (sum == 0).
  - All flags are registered together with sum.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds chunk k using the carry registered by stage k-1 (carry0 for stage 0).
  - Each stage latches: the completed low chunks, the still-pending high chunks of a and b_eff, the chunk carry, and a valid bit.
  - The last stage register drives sum, cout, overflow and zero directly.
- Handshake:
  - advance = !out_valid || out_ready. This single global enable gates every stage register.
  - in_ready = advance.
  - An operand set is accepted when in_valid && in_ready.
  - Valid bits shift only on advance. A bubble (no accept) inserts valid=0.
- Latency and throughput:
  - Exactly STAGES cycles from the accepting edge to out_valid=1, with no stall.
  - Throughput is one result per cycle; results are delivered in order.
- Stall: while out_valid=1 and out_ready=0:
  - every stage freezes and in_ready=0;
  - sum and the flags stay stable;
  - no data is lost or duplicated.
- Combined transfer: out_ready=1 and in_valid=1 in the same cycle completes the output transfer and the input accept on the same edge.
- STAGES=1: the whole add happens in one stage; latency is 1.
- Reset:
  - Asserting rst_n=0 at any time, including mid-operation, immediately clears all valid bits and all data registers.
  - Reset values: out_valid=0, sum=0, cout=0, overflow=0.
  - zero: 0 while out_valid=0; it is the registered flag, not decoded from the cleared sum.
  - in_ready=1 during reset.
  - In-flight operations are discarded. After rst_n rises, no stale result ever appears.
- Inputs a, b, cin and sub_en are don't-care when in_valid=0 and must not affect state.

Test Plan (WIDTH=32, STAGES=4, out_ready=1 unless noted):
- Add 0xFFFFFFFF + 0x00000001, cin=0 -> 4 cycles after accept: sum=0x00000000, cout=1, overflow=0, zero=1.
- Add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, overflow=1, zero=0. Sub 0x00000005 - 0x00000005 -> sum=0, cout=1, overflow=0, zero=1.
- Sub 0x80000000 - 0x00000001 -> sum=0x7FFFFFFF, cout=1, overflow=1. Sub 0 - 1 with cin=1 -> sum=0xFFFFFFFE, cout=0.
- 8 back-to-back random ops, one per cycle -> 8 correct results in order on consecutive cycles, the first at cycle 4; in_ready stays 1 throughout.
- Fill the pipeline, then hold out_ready=0 for 3 cycles -> in_ready=0 and sum/flags stable for those cycles; on release, all 4 results drain in order with none lost.
- Pulse rst_n low with 3 operations in flight -> out_valid=0 and sum=0 asynchronously; after release with in_valid=0 for 6 cycles, out_valid stays 0.
